tiny_rr_mux: RTL

TINY_RR_MUX -- requirements
Module: tiny_rr_mux

---
 rtl/tiny_rr_mux.sv | 91 +++++++++
 1 files changed

// File: rtl/tiny_rr_mux.sv
// Two-source round-robin merge onto one registered valid/ready stream.
// Each source also has a saturating count of accepted beats.
module tiny_rr_mux #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [31:0]      a_data,
  input  logic [31:0]      a_addr,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [31:0]      b_data,
  input  logic [31:0]      b_addr,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_data,
  output logic [31:0]      o_addr,
  output logic             o_src,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // state | meaning
  // IDLE  | output register empty, o_valid=0
  // BUSY  | output register holds a beat, o_valid=1
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic       last_gnt;
  logic       out_free;
  logic       gnt_a;
  logic       gnt_b;

  assign out_free = (state == IDLE) | o_ready;
  // A wins when alone or when B was served last; B symmetrically.
  assign gnt_a    = a_valid & (~b_valid | (last_gnt == SRC_B));
  assign gnt_b    = b_valid & (~a_valid | (last_gnt == SRC_A));
  assign a_ready  = out_free & gnt_a;
  assign b_ready  = out_free & gnt_b;
  assign o_valid  = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      o_data   <= '0;
      o_addr   <= '0;
      o_src    <= SRC_A;
      last_gnt <= SRC_B;
    end else if (out_free) begin
      if (gnt_a) begin
        state    <= BUSY;
        o_data   <= a_data;
        o_addr   <= a_addr;
        o_src    <= SRC_A;
        last_gnt <= SRC_A;
      end else if (gnt_b) begin
        state    <= BUSY;
        o_data   <= b_data;
        o_addr   <= b_addr;
        o_src    <= SRC_B;
        last_gnt <= SRC_B;
      end else begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_valid && a_ready && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_ONE;
      if (b_valid && b_ready && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_ONE;
    end
  end

endmodule
